// File: rtl/uart_cmd_rx.sv
// 8N1 serial receiver that pairs consecutive bytes into a 16-bit command
// with a sticky ready flag and an inter-byte timeout.
module uart_cmd_rx #(
    parameter int BAUD_DIV     = 5208,
    parameter int TIMEOUT_CLKS = 104160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frame_err
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO} asm_state_t;

    bit_state_t    bit_state, bit_next;
    asm_state_t    asm_state, asm_next;
    logic          rx_meta, rx_s, rx_d;
    logic          rx_fall;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    hi_byte;
    logic [TW-1:0] to_cnt;
    logic          start_smp, data_smp, stop_smp, sample;
    logic          byte_vld;
    logic          load_hi, pair_done;

    // Synchronizer preset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value, forming a true shift chain.
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign rx_fall = rx_d & ~rx_s;

    // ---------------- bit-level FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bit_state <= B_IDLE;
        else        bit_state <= bit_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns bit_next and no latch is inferred.
        bit_next = bit_state;
        unique case (bit_state)
            B_IDLE:  if (rx_fall) bit_next = B_START;
            B_START: if (start_smp) bit_next = rx_s ? B_IDLE : B_DATA;
            B_DATA:  if (data_smp && bit_idx == 3'd7) bit_next = B_STOP;
            B_STOP:  if (stop_smp) bit_next = B_IDLE;
            default: bit_next = B_IDLE;
        endcase
    end

    always_comb begin
        start_smp = (bit_state == B_START) && (baud_cnt == HALF_LAST);
        data_smp  = (bit_state == B_DATA)  && (baud_cnt == BIT_LAST);
        stop_smp  = (bit_state == B_STOP)  && (baud_cnt == BIT_LAST);
        sample    = start_smp | data_smp | stop_smp;
        byte_vld  = stop_smp & rx_s;
        frame_err = stop_smp & ~rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (bit_state == B_IDLE || bit_next != bit_state || sample)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (start_smp) begin
                bit_idx <= '0;
            end else if (data_smp) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
        end
    end

    // ---------------- byte-pair assembler ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) asm_state <= WAIT_HI;
        else        asm_state <= asm_next;
    end

    // A valid low byte takes precedence over a timeout landing in the same cycle.
    always_comb begin
        asm_next = asm_state;
        unique case (asm_state)
            WAIT_HI: if (byte_vld) asm_next = WAIT_LO;
            WAIT_LO: if (byte_vld || frame_err || to_cnt == TO_LAST) asm_next = WAIT_HI;
            default: asm_next = WAIT_HI;
        endcase
    end

    always_comb begin
        load_hi   = (asm_state == WAIT_HI) && byte_vld;
        pair_done = (asm_state == WAIT_LO) && byte_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte <= '0;
            to_cnt  <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (load_hi)
                hi_byte <= shift_reg;

            if (asm_state == WAIT_LO && asm_next == WAIT_LO)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;

            if (pair_done)
                cmd <= {hi_byte, shift_reg};

            // Completion beats a coincident clear so a fresh command is never lost.
            if (pair_done)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: drives serial frames, scoreboards expected
// commands in a queue and checks them with immediate assertions.
module tb_uart_cmd_rx;

    localparam int BAUD    = 16;
    localparam int TIMEOUT = 20 * BAUD;
    // Negedge index (from the start-bit falling edge) at which cmd_rdy first reads high.
    localparam int LAT     = 3 + BAUD / 2 + 9 * BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frame_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          fe_cnt   = 0;
    int          rise_cnt = 0;
    logic        rdy_q    = 1'b0;
    logic [15:0] exp_q[$];

    int          fe0, r0;

    uart_cmd_rx #(.BAUD_DIV(BAUD), .TIMEOUT_CLKS(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (rx),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (cmd_rdy === 1'b1 && rdy_q !== 1'b1) rise_cnt++;
        rdy_q = cmd_rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives nclk clocks of an 8N1 frame starting at a negedge; optionally checks
    // cmd_rdy latency and drops clr_cmd_rdy as soon as cmd_rdy is seen high.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int nclk,
                               input bit chk_lat, input bit rel_clr);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int n = 0; n < nclk; n++) begin
            if (n % BAUD == 0) rx = fr[n / BAUD];
            @(negedge clk);
            if (rel_clr && clr_cmd_rdy && cmd_rdy) clr_cmd_rdy = 1'b0;
            if (chk_lat && n + 1 == LAT - 1) check("lat_before", {31'd0, cmd_rdy}, 32'd0);
            if (chk_lat && n + 1 == LAT)     check("lat_after",  {31'd0, cmd_rdy}, 32'd1);
        end
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        drive_frame(b, 1'b1, 10 * BAUD, 1'b0, 1'b0);
    endtask

    task automatic check_pair(input string tag);
        logic [15:0] e;
        int waited;
        waited = 0;
        while (cmd_rdy !== 1'b1 && waited < 4 * BAUD) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rdy"}, {31'd0, cmd_rdy}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_cmd"}, {16'd0, cmd}, {16'd0, e});
        end
    endtask

    task automatic clear_rdy(input string tag);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check({tag, "_clr"}, {31'd0, cmd_rdy}, 32'd0);
    endtask

    initial begin
        rx          = 1'b1;
        clr_cmd_rdy = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", {16'd0, cmd}, 32'h0);
        check("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_fe",  {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic pair with exact latency check.
        exp_q.push_back(16'hA53C);
        send(8'hA5);
        drive_frame(8'h3C, 1'b1, 10 * BAUD, 1'b1, 1'b0);
        check_pair("t1");
        check("t1_no_fe", fe_cnt, 32'd0);

        // Clear keeps cmd; completion coinciding with clear keeps cmd_rdy set.
        clear_rdy("t2a");
        check("t2_cmd_hold", {16'd0, cmd}, 32'hA53C);
        exp_q.push_back(16'h0003);
        send(8'h00);
        clr_cmd_rdy = 1'b1;
        drive_frame(8'h03, 1'b1, 10 * BAUD, 1'b0, 1'b1);
        check("t2_clr_released", {31'd0, clr_cmd_rdy}, 32'd0);
        check_pair("t2");
        @(negedge clk);
        check("t2_rdy_stays", {31'd0, cmd_rdy}, 32'd1);
        clear_rdy("t2b");

        // Short start glitch is rejected.
        fe0 = fe_cnt;
        r0  = rise_cnt;
        rx  = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("t3_no_fe",  fe_cnt - fe0, 32'd0);
        check("t3_no_rdy", rise_cnt - r0, 32'd0);
        exp_q.push_back(16'h1234);
        send(8'h12);
        send(8'h34);
        check_pair("t3");
        clear_rdy("t3");

        // Inter-byte timeout discards the lone high byte.
        r0 = rise_cnt;
        send(8'hFF);
        repeat (TIMEOUT + 10) @(negedge clk);
        exp_q.push_back(16'h1122);
        send(8'h11);
        send(8'h22);
        check_pair("t4");
        check("t4_one_rise", rise_cnt - r0, 32'd1);
        clear_rdy("t4");

        // Bad stop bit on the low byte.
        fe0 = fe_cnt;
        r0  = rise_cnt;
        send(8'hAA);
        drive_frame(8'h55, 1'b0, 10 * BAUD, 1'b0, 1'b0);
        repeat (2 * BAUD) @(negedge clk);
        check("t5_fe_once", fe_cnt - fe0, 32'd1);
        check("t5_no_rdy",  rise_cnt - r0, 32'd0);
        check("t5_cmd_hold", {16'd0, cmd}, 32'h1122);
        exp_q.push_back(16'hC30F);
        send(8'hC3);
        send(8'h0F);
        check_pair("t5");

        // Reset during bit 4 of the low byte, with cmd_rdy still set.
        send(8'h77);
        drive_frame(8'h55, 1'b1, 5 * BAUD + BAUD / 2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cmd", {16'd0, cmd}, 32'h0);
        check("t6_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t6_rst_fe",  {31'd0, frame_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(16'h5AA5);
        send(8'h5A);
        send(8'hA5);
        check_pair("t6");
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Upstream feeder of the command processor: receives 8N1 serial bytes on RX from the BLE module and assembles byte pairs into one 16-bit command.
- Presents the command with a sticky ready flag that the command processor clears when it captures the command.
- Integrates the bit-level receiver, the byte-pair assembler and an inter-byte timeout in one block.

Parameters:
- BAUD_DIV, 5208: clk cycles per bit (50 MHz / 9600 baud); must be even and at least 8.
- TIMEOUT_CLKS, 104160: maximum clk cycles allowed between high-byte completion and low-byte completion (20 bit times).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  asynchronous serial data; idle high
- clr_cmd_rdy  input  1  consumer pulse: command captured, clear cmd_rdy
- cmd  output  16  last completed command; {first byte, second byte}
- cmd_rdy  output  1  sticky: a complete, unconsumed command is on cmd
- frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset values (asynchronous): cmd=16'h0000, cmd_rdy=0, frame_err=0, both FSMs idle, all counters 0, RX synchronizer flops preset to 1.
- RX passes through 2 flops (rx_s) before any use; a falling edge is detected on rx_s against a third delayed flop.
- Bit FSM states: IDLE, START, DATA, STOP. Baud counter clears on every state entry and after every sample.
  - IDLE: falling edge on rx_s -> START.
  - START: at count BAUD_DIV/2-1, sample rx_s. If 0 -> DATA (bit index 0). If 1 -> IDLE (glitch rejected; no byte, no error).
  - DATA: at each count BAUD_DIV-1, shift rx_s into the byte LSB-first. After the 8th sample -> STOP.
  - STOP: at count BAUD_DIV-1, sample rx_s. If 1, byte_vld pulses for 1 cycle. If 0, frame_err pulses for 1 cycle and the byte is discarded. Either way -> IDLE in the same cycle, so a start bit is accepted from mid-stop-bit onward.
- Assembler states: WAIT_HI, WAIT_LO.
  - WAIT_HI + byte_vld: load hold register hi_byte, clear timeout counter -> WAIT_LO. cmd and cmd_rdy are untouched.
  - WAIT_LO + byte_vld: cmd <= {hi_byte, byte}; cmd_rdy set on the following clock edge; -> WAIT_HI. Latency from the low-byte stop-sample edge to cmd_rdy high is 1 clk.
  - WAIT_LO: timeout counter increments every cycle. At TIMEOUT_CLKS-1 without byte_vld, discard hi_byte -> WAIT_HI. byte_vld in that same cycle wins over timeout.
  - WAIT_LO + frame_err: discard hi_byte -> WAIT_HI.
  - frame_err in WAIT_HI: no state change.
- cmd changes only on pair completion and is stable otherwise. The consumer may therefore sample cmd in the same cycle it asserts clr_cmd_rdy.
- cmd_rdy clear rules:
  - clr_cmd_rdy clears it on the next edge.
  - If pair completion and clr_cmd_rdy coincide, set wins and cmd_rdy stays 1.
  - A new pair completing while cmd_rdy=1 overwrites cmd and keeps cmd_rdy=1; no overrun flag.
  - clr_cmd_rdy while cmd_rdy=0 has no effect.
- RX held low indefinitely: one frame_err after the first start bit, then no further starts until a rising then falling edge occurs.
- Reset asserted mid-byte or mid-pair: everything returns to reset values immediately; the partial byte or pair is lost; hi_byte is not retained.
- Counter widths: $clog2(BAUD_DIV) and $clog2(TIMEOUT_CLKS); no wrap occurs within any state.

Test Plan:
- Reset, then frames 8'hA5 then 8'h3C with BAUD_DIV=16 -> cmd=16'hA53C and cmd_rdy=1 exactly 1 clk after the second stop sample; frame_err never pulses.
- With cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next clk and cmd still 16'hA53C. Then send 8'h00, 8'h03 with clr_cmd_rdy asserted in the completion cycle -> cmd=16'h0003 and cmd_rdy=1.
- 4-clk low glitch on RX (BAUD_DIV=16) -> returns to IDLE; no byte_vld, no frame_err. A following pair 8'h12, 8'h34 gives cmd=16'h1234.
- Send 8'hFF, then wait TIMEOUT_CLKS+10 clks, then send 8'h11, 8'h22 -> cmd=16'h1122 (not 16'hFF11) and cmd_rdy rises once.
- Second byte sent with stop bit forced 0 -> one-cycle frame_err and no cmd_rdy. A following pair 8'hC3, 8'h0F gives cmd=16'hC30F.
- Assert rst_n low during bit 4 of the low byte -> all outputs reset immediately. After release, a pair 8'h5A, 8'hA5 gives cmd=16'h5AA5.
